// File: rtl/cr_xp10_decompPKG.sv
// Shared XP10 decompressor types: MTF header/symbol bus layouts and the MTF arbiter state encoding.
package cr_xp10_decompPKG;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GAP, ARB_DATA} mtf_arb_state_e;

  localparam logic [3:0] XP10_FRAMING_TRAILER = 4'hf;

  // framing[3] marks end-of-block; 4'hf is the frame trailer.
  typedef struct packed {
    logic [3:0]  framing;
    logic [59:0] data;
  } lz_symbol_bus_t;

  typedef struct packed {
    logic [7:0]  blk_type;
    logic [23:0] blk_len;
  } bhp_mtf_hdr_bus_t;

  function automatic logic is_trailer(input lz_symbol_bus_t b);
    return b.framing == XP10_FRAMING_TRAILER;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first request at or after ptr.
module cr_xp10_decomp_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] sel;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      sel = IW'((int'(ptr) + k) % N);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_xp10_decomp_mtf_arb.sv
// Frame-granular round-robin arbiter sharing one MTF stage between NUM_SRC decoders.
// The owner keeps both header and symbol channels until its trailer beat is accepted.
module cr_xp10_decomp_mtf_arb
  import cr_xp10_decompPKG::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_hdr_valid,
  input  bhp_mtf_hdr_bus_t           src_hdr_bus [NUM_SRC],
  output logic [NUM_SRC-1:0]         src_hdr_ready,
  input  logic [NUM_SRC-1:0]         src_dp_valid,
  input  lz_symbol_bus_t             src_dp_bus [NUM_SRC],
  output logic [NUM_SRC-1:0]         src_dp_ready,
  output logic                       arb_hdr_valid,
  output bhp_mtf_hdr_bus_t           arb_hdr_bus,
  input  logic                       mtf_hdr_ready,
  output logic                       arb_dp_valid,
  output lz_symbol_bus_t             arb_dp_bus,
  input  logic                       mtf_dp_ready,
  output logic [NUM_SRC-1:0]         arb_grant,
  output logic                       frame_done,
  output logic [$clog2(NUM_SRC)-1:0] frame_done_src
);

  localparam int IW = $clog2(NUM_SRC);

  mtf_arb_state_e     state, state_nxt;
  logic [NUM_SRC-1:0] grant_nxt, req, pick;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt, owner;
  logic               done_nxt, trailer, release_frame;

  assign req = src_hdr_valid | src_dp_valid;

  cr_xp10_decomp_rr_pick #(.N(NUM_SRC)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_grant[i]) owner = IW'(i);
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = arb_grant;
    rr_ptr_nxt    = rr_ptr;
    done_nxt      = 1'b0;
    release_frame = 1'b0;
    arb_hdr_valid = 1'b0;
    arb_dp_valid  = 1'b0;
    src_hdr_ready = '0;
    src_dp_ready  = '0;
    arb_hdr_bus   = src_hdr_bus[owner];
    arb_dp_bus    = src_dp_bus[owner];
    trailer       = src_dp_valid[owner] && is_trailer(arb_dp_bus);

    unique case (state)
      ARB_IDLE: begin
        if (|req) begin
          grant_nxt = pick;
          state_nxt = ARB_GAP;
        end
      end
      ARB_GAP: begin
        // A trailer closes the frame even if a header is also pending.
        if (trailer) begin
          arb_dp_valid         = 1'b1;
          src_dp_ready[owner]  = mtf_dp_ready;
          release_frame        = mtf_dp_ready;
        end else if (src_hdr_valid[owner]) begin
          arb_hdr_valid        = 1'b1;
          src_hdr_ready[owner] = mtf_hdr_ready;
          if (mtf_hdr_ready) state_nxt = ARB_DATA;
        end
      end
      ARB_DATA: begin
        arb_dp_valid        = src_dp_valid[owner];
        src_dp_ready[owner] = mtf_dp_ready;
        if (src_dp_valid[owner] && mtf_dp_ready && arb_dp_bus.framing[3]) begin
          if (trailer) release_frame = 1'b1;
          else         state_nxt     = ARB_GAP;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase

    if (release_frame) begin
      state_nxt  = ARB_IDLE;
      grant_nxt  = '0;
      done_nxt   = 1'b1;
      rr_ptr_nxt = (owner == IW'(NUM_SRC - 1)) ? '0 : owner + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ARB_IDLE;
      arb_grant      <= '0;
      rr_ptr         <= '0;
      frame_done     <= 1'b0;
      frame_done_src <= '0;
    end else begin
      state      <= state_nxt;
      arb_grant  <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      frame_done <= done_nxt;
      if (done_nxt) frame_done_src <= owner;
    end
  end

endmodule

// File: tb/tb_cr_xp10_decomp_mtf_arb.sv
// Bench for the MTF frame arbiter: directed vector table, stall/reset sequences, random frames vs a queue model.
module tb_cr_xp10_decomp_mtf_arb;
  import cr_xp10_decompPKG::*;

  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     src_hdr_valid, src_hdr_ready, src_dp_valid, src_dp_ready, arb_grant;
  bhp_mtf_hdr_bus_t src_hdr_bus [N];
  lz_symbol_bus_t   src_dp_bus [N];
  logic             arb_hdr_valid, mtf_hdr_ready, arb_dp_valid, mtf_dp_ready, frame_done;
  bhp_mtf_hdr_bus_t arb_hdr_bus;
  lz_symbol_bus_t   arb_dp_bus;
  logic [0:0]       frame_done_src;

  int errors = 0;
  int checks = 0;

  cr_xp10_decomp_mtf_arb #(.NUM_SRC(N)) dut (
    .clk(clk), .rst(rst),
    .src_hdr_valid(src_hdr_valid), .src_hdr_bus(src_hdr_bus), .src_hdr_ready(src_hdr_ready),
    .src_dp_valid(src_dp_valid), .src_dp_bus(src_dp_bus), .src_dp_ready(src_dp_ready),
    .arb_hdr_valid(arb_hdr_valid), .arb_hdr_bus(arb_hdr_bus), .mtf_hdr_ready(mtf_hdr_ready),
    .arb_dp_valid(arb_dp_valid), .arb_dp_bus(arb_dp_bus), .mtf_dp_ready(mtf_dp_ready),
    .arb_grant(arb_grant), .frame_done(frame_done), .frame_done_src(frame_done_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_dp(input logic [3:0] fr, input int tag, input int s);
    return {fr, 60'(tag * 16 + s)};
  endfunction

  task automatic clear_in();
    src_hdr_valid = '0;
    src_dp_valid  = '0;
    mtf_hdr_ready = 1'b0;
    mtf_dp_ready  = 1'b0;
    for (int s = 0; s < N; s++) begin
      src_hdr_bus[s] = '0;
      src_dp_bus[s]  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle: drive just after the edge, return at the following negedge for sampling.
  task automatic drive(input logic [1:0] hv, input logic [1:0] dv, input logic [3:0] fr0,
                       input logic [3:0] fr1, input logic hr, input logic dr, input int tag);
    @(posedge clk);
    #1;
    src_hdr_valid  = hv;
    src_dp_valid   = dv;
    src_hdr_bus[0] = bhp_mtf_hdr_bus_t'(32'(tag * 16));
    src_hdr_bus[1] = bhp_mtf_hdr_bus_t'(32'(tag * 16 + 1));
    src_dp_bus[0]  = exp_dp(fr0, tag, 0);
    src_dp_bus[1]  = exp_dp(fr1, tag, 1);
    mtf_hdr_ready  = hr;
    mtf_dp_ready   = dr;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] hv, dv;
    logic [3:0] fr0, fr1;
    logic       hr, dr;
    logic [1:0] grant;
    logic       ahv, adv;
    logic [1:0] shr, sdr;
    logic       done, dsrc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] hv, input logic [1:0] dv, input logic [3:0] fr0,
                     input logic [3:0] fr1, input logic hr, input logic dr, input logic [1:0] g,
                     input logic ahv, input logic adv, input logic [1:0] shr, input logic [1:0] sdr,
                     input logic done, input logic dsrc);
    vec_t v;
    v.hv = hv; v.dv = dv; v.fr0 = fr0; v.fr1 = fr1; v.hr = hr; v.dr = dr;
    v.grant = g; v.ahv = ahv; v.adv = adv; v.shr = shr; v.sdr = sdr; v.done = done; v.dsrc = dsrc;
    tbl.push_back(v);
  endtask

  typedef struct {
    logic        is_hdr;
    logic [63:0] val;
  } item_t;

  item_t items [N][$];

  initial begin
    vec_t  v;
    int    own;
    item_t it;
    int    pos [N];
    bit    pres [N];
    bit    hs [N];
    int    model_owner, fair_src, nhs, src, cyc, nb, nd;
    bit    fair_pending, done_exp, done_src_exp, hx, dx;
    logic [3:0] fr;

    rst = 1'b1;
    clear_in();
    // Reset state with every input trying to provoke activity.
    src_hdr_valid = '1; src_dp_valid = '1; mtf_hdr_ready = 1'b1; mtf_dp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset grant", arb_grant, 0);
    chk("reset arb valids", {arb_hdr_valid, arb_dp_valid}, 0);
    chk("reset src readies", {src_hdr_ready, src_dp_ready}, 0);
    chk("reset frame_done", frame_done, 0);
    do_reset();

    // hv, dv, fr0, fr1, hr, dr | grant, ahv, adv, shr, sdr, done, dsrc
    // Both sources request together after reset: src0 first, trailer outranks a pending header.
    add(2'b11, 2'b00, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b11, 2'b00, 4'h0, 4'h0, 1, 1, 2'b01, 1, 0, 2'b01, 2'b00, 0, 0);
    add(2'b10, 2'b11, 4'h8, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b11, 2'b11, 4'hf, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b10, 2'b10, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0);
    add(2'b10, 2'b10, 4'h0, 4'h0, 1, 1, 2'b10, 1, 0, 2'b10, 2'b00, 0, 0);
    add(2'b00, 2'b10, 4'h0, 4'h8, 1, 1, 2'b10, 0, 1, 2'b00, 2'b10, 0, 0);
    add(2'b00, 2'b10, 4'h0, 4'hf, 1, 1, 2'b10, 0, 1, 2'b00, 2'b10, 0, 0);
    add(2'b00, 2'b00, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 1, 1);
    // Src0 alone: header (first stalled), 4,4,c, dp stalled in GAP, header, 4, trailer.
    add(2'b01, 2'b00, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b00, 4'h0, 4'h0, 0, 1, 2'b01, 1, 0, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b00, 4'h0, 4'h0, 1, 1, 2'b01, 1, 0, 2'b01, 2'b00, 0, 0);
    add(2'b00, 2'b01, 4'h4, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b01, 4'h4, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b01, 4'hc, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b01, 4'h4, 4'h0, 1, 1, 2'b01, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b01, 2'b01, 4'h4, 4'h0, 1, 1, 2'b01, 1, 0, 2'b01, 2'b00, 0, 0);
    add(2'b00, 2'b01, 4'h4, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b01, 4'hf, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b00, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0);
    // Header-less frame from src0 (pointer now at src1, src0 is the only requester).
    add(2'b00, 2'b01, 4'hf, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b00, 2'b01, 4'hf, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b00, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0);
    // Multi-block src1 frame while src0 waits; src0 only after src1's trailer.
    add(2'b11, 2'b00, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b11, 2'b00, 4'h0, 4'h0, 1, 1, 2'b10, 1, 0, 2'b10, 2'b00, 0, 0);
    add(2'b01, 2'b10, 4'h0, 4'h8, 1, 1, 2'b10, 0, 1, 2'b00, 2'b10, 0, 0);
    add(2'b11, 2'b00, 4'h0, 4'h0, 1, 1, 2'b10, 1, 0, 2'b10, 2'b00, 0, 0);
    add(2'b01, 2'b10, 4'h0, 4'h8, 1, 1, 2'b10, 0, 1, 2'b00, 2'b10, 0, 0);
    add(2'b01, 2'b10, 4'h0, 4'hf, 1, 1, 2'b10, 0, 1, 2'b00, 2'b10, 0, 0);
    add(2'b01, 2'b00, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 1, 1);
    add(2'b01, 2'b00, 4'h0, 4'h0, 1, 1, 2'b01, 1, 0, 2'b01, 2'b00, 0, 0);
    add(2'b00, 2'b01, 4'hf, 4'h0, 1, 1, 2'b01, 0, 1, 2'b00, 2'b01, 0, 0);
    add(2'b00, 2'b00, 4'h0, 4'h0, 1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.hv, v.dv, v.fr0, v.fr1, v.hr, v.dr, i);
      own = v.grant[1] ? 1 : 0;
      chk($sformatf("row%0d grant", i), arb_grant, v.grant);
      chk($sformatf("row%0d arb_hdr_valid", i), arb_hdr_valid, v.ahv);
      chk($sformatf("row%0d arb_dp_valid", i), arb_dp_valid, v.adv);
      chk($sformatf("row%0d src_hdr_ready", i), src_hdr_ready, v.shr);
      chk($sformatf("row%0d src_dp_ready", i), src_dp_ready, v.sdr);
      chk($sformatf("row%0d frame_done", i), frame_done, v.done);
      if (v.done) chk($sformatf("row%0d frame_done_src", i), frame_done_src, v.dsrc);
      if (v.adv) chk($sformatf("row%0d dp payload", i), arb_dp_bus,
                     exp_dp(own == 1 ? v.fr1 : v.fr0, i, own));
      if (v.ahv) chk($sformatf("row%0d hdr payload", i), arb_hdr_bus, 64'(i * 16 + own));
    end

    // Ten cycles of downstream stall in DATA with src1 requesting.
    do_reset();
    drive(2'b01, 2'b00, 4'h0, 4'h0, 1, 1, 70);
    chk("stall idle grant", arb_grant, 0);
    drive(2'b11, 2'b00, 4'h0, 4'h0, 1, 1, 71);
    chk("stall hdr fwd", {arb_hdr_valid, src_hdr_ready}, {1'b1, 2'b01});
    for (int k = 0; k < 10; k++) begin
      drive(2'b10, 2'b01, 4'h4, 4'h0, 1, 0, 72);
      chk($sformatf("stall%0d grant", k), arb_grant, 2'b01);
      chk($sformatf("stall%0d valid/ready", k), {arb_dp_valid, src_dp_ready, src_hdr_ready}, {1'b1, 4'b0});
      chk($sformatf("stall%0d payload", k), arb_dp_bus, exp_dp(4'h4, 72, 0));
    end
    drive(2'b10, 2'b01, 4'h4, 4'h0, 1, 1, 72);
    chk("stall release ready", {arb_dp_valid, src_dp_ready}, {1'b1, 2'b01});
    drive(2'b10, 2'b01, 4'hf, 4'h0, 1, 1, 73);
    chk("stall trailer", {arb_dp_valid, src_dp_ready}, {1'b1, 2'b01});
    chk("stall trailer payload", arb_dp_bus, exp_dp(4'hf, 73, 0));
    drive(2'b10, 2'b00, 4'h0, 4'h0, 1, 1, 74);
    chk("stall done", {frame_done, frame_done_src, arb_grant}, {1'b1, 1'b0, 2'b00});
    drive(2'b10, 2'b00, 4'h0, 4'h0, 1, 1, 75);
    chk("src1 grant after stall", {arb_grant, arb_hdr_valid}, {2'b10, 1'b1});
    drive(2'b00, 2'b10, 4'h0, 4'h0, 1, 1, 76);
    chk("src1 data beat", {arb_dp_valid, src_dp_ready}, {1'b1, 2'b10});

    // Asynchronous reset while src1 is in DATA; pointer must return to src0.
    @(posedge clk);
    #3 rst = 1'b1;
    src_hdr_valid = 2'b11; src_dp_valid = 2'b11;
    src_dp_bus[0] = exp_dp(4'h4, 80, 0); src_dp_bus[1] = exp_dp(4'h4, 80, 1);
    mtf_hdr_ready = 1'b1; mtf_dp_ready = 1'b1;
    @(negedge clk);
    chk("midrst grant", arb_grant, 0);
    chk("midrst valids/readies", {arb_hdr_valid, arb_dp_valid, src_hdr_ready, src_dp_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst idle", {arb_grant, arb_hdr_valid, arb_dp_valid}, 0);
    @(negedge clk);
    chk("post-rst first grant", arb_grant, 2'b01);

    // Random frames from both sources against a per-source queue model.
    do_reset();
    for (int s = 0; s < N; s++) begin
      for (int f = 0; f < 8; f++) begin
        if ($urandom_range(0, 3) != 0) begin
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) begin
            it.is_hdr = 1'b1; it.val = 64'($urandom);
            items[s].push_back(it);
            nd = $urandom_range(0, 3);
            for (int d = 0; d <= nd; d++) begin
              fr = (d == nd) ? 4'($urandom_range(8, 14)) : 4'($urandom_range(0, 7));
              it.is_hdr = 1'b0; it.val = {fr, 60'({$urandom, $urandom})};
              items[s].push_back(it);
            end
          end
        end
        it.is_hdr = 1'b0; it.val = {XP10_FRAMING_TRAILER, 60'({$urandom, $urandom})};
        items[s].push_back(it);
      end
      pos[s] = 0; pres[s] = 1'b0; hs[s] = 1'b0;
    end
    model_owner = -1; fair_pending = 1'b0; fair_src = 0; done_exp = 1'b0; done_src_exp = 1'b0;
    cyc = 0;
    while ((pos[0] < items[0].size() || pos[1] < items[1].size()) && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int s = 0; s < N; s++) begin
        if (pres[s] && hs[s]) begin pos[s]++; pres[s] = 1'b0; end
        if (!pres[s] && pos[s] < items[s].size() && $urandom_range(0, 2) != 0) pres[s] = 1'b1;
        src_hdr_valid[s] = 1'b0; src_dp_valid[s] = 1'b0;
        src_hdr_bus[s] = '0; src_dp_bus[s] = '0;
        if (pres[s]) begin
          it = items[s][pos[s]];
          if (it.is_hdr) begin src_hdr_valid[s] = 1'b1; src_hdr_bus[s] = bhp_mtf_hdr_bus_t'(it.val[31:0]); end
          else begin src_dp_valid[s] = 1'b1; src_dp_bus[s] = lz_symbol_bus_t'(it.val); end
        end
      end
      mtf_hdr_ready = ($urandom_range(0, 3) != 0);
      mtf_dp_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rnd non-owner ready", (src_hdr_ready | src_dp_ready) & ~arb_grant, 0);
      chk("rnd hdr+dp same cycle", arb_hdr_valid && arb_dp_valid, 0);
      chk("rnd frame_done", frame_done, done_exp);
      if (done_exp) chk("rnd frame_done_src", frame_done_src, done_src_exp);
      done_exp = 1'b0;
      nhs = 0; src = 0;
      for (int s = 0; s < N; s++) begin
        hs[s] = 1'b0;
        if (pres[s]) hs[s] = items[s][pos[s]].is_hdr ? src_hdr_ready[s] : src_dp_ready[s];
        if (hs[s]) begin nhs++; src = s; end
      end
      hx = arb_hdr_valid && mtf_hdr_ready;
      dx = arb_dp_valid && mtf_dp_ready;
      chk("rnd transfer count", nhs, (hx || dx) ? 1 : 0);
      if (nhs == 1) begin
        it = items[src][pos[src]];
        chk("rnd channel", hx, it.is_hdr);
        if (it.is_hdr) chk("rnd hdr payload", arb_hdr_bus, it.val);
        else           chk("rnd dp payload", arb_dp_bus, it.val);
        if (model_owner < 0) begin
          if (fair_pending) chk("rnd round-robin owner", src, fair_src);
          fair_pending = 1'b0;
          model_owner = src;
        end else begin
          chk("rnd frame interleave", src, model_owner);
        end
        if (!it.is_hdr && it.val[63:60] == XP10_FRAMING_TRAILER) begin
          done_exp = 1'b1; done_src_exp = 1'(src);
          model_owner = -1;
          fair_pending = pres[1 - src];
          fair_src = 1 - src;
        end
      end
    end
    for (int s = 0; s < N; s++) begin
      if (pres[s] && hs[s]) pos[s]++;
      chk($sformatf("rnd src%0d all items delivered", s), pos[s], items[s].size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
